// File: rtl/serial_bit_feeder_if.sv
// Word handshake into the serial bit feeder: upstream offers din/din_valid,
// the feeder answers with din_ready.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector: one word buffered ahead,
// words shifted back-to-back one bit per clock, x parked at IDLE_BIT when empty.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  serial_bit_feeder_if.slave  up,
  output logic                x,
  output logic                busy,
  output logic                word_done
);

  localparam int             CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic             ready_q;

  logic accept;
  logic load_pt;

  assign up.din_ready = ready_q;
  assign accept       = up.din_valid & ready_q;
  assign load_pt      = (state == IDLE) || (cnt == '0);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // Bits still to go after the one just put on x, kept aligned so the next
  // one always sits at the same end of the register.
  function automatic logic [WIDTH-1:0] rest(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      ready_q   <= 1'b1;
      x         <= IDLE_BIT;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else if (load_pt) begin
      // A pending word always wins; ready is low then, so no accept can collide.
      if (pend_full) begin
        x         <= first_bit(pend);
        shreg     <= rest(pend);
        cnt       <= CNT_MAX;
        state     <= SHIFT;
        busy      <= 1'b1;
        word_done <= 1'b0;
        pend_full <= 1'b0;
        ready_q   <= 1'b1;
      end else if (accept) begin
        x         <= first_bit(up.din);
        shreg     <= rest(up.din);
        cnt       <= CNT_MAX;
        state     <= SHIFT;
        busy      <= 1'b1;
        word_done <= 1'b0;
      end else begin
        x         <= IDLE_BIT;
        cnt       <= '0;
        state     <= IDLE;
        busy      <= 1'b0;
        word_done <= 1'b0;
      end
    end else begin
      x         <= first_bit(shreg);
      shreg     <= rest(shreg);
      cnt       <= cnt - CNT_ONE;
      word_done <= (cnt == CNT_ONE);
      if (accept) begin
        pend      <= up.din;
        pend_full <= 1'b1;
        ready_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first and LSB-first instances fed
// the same words, checked every cycle against a bit-queue model.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic x_m, busy_m, done_m;
  logic x_l, busy_l, done_l;

  serial_bit_feeder_if #(.WIDTH(W)) if_m ();
  serial_bit_feeder_if #(.WIDTH(W)) if_l ();

  assign if_m.din       = din;
  assign if_m.din_valid = din_valid;
  assign if_l.din       = din;
  assign if_l.din_valid = din_valid;

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(0), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .rst(rst), .up(if_m.slave),
    .x(x_m), .busy(busy_m), .word_done(done_m)
  );

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(1), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .up(if_l.slave),
    .x(x_l), .busy(busy_l), .word_done(done_l)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word appends its bits to a stream; each edge shows
  // the next stream bit, or idle if the stream is empty. A second word can
  // be held only while fewer than W bits are still waiting.
  bit qm[$];
  bit ql[$];
  bit qd[$];
  logic ex_m = 1'b1, ex_l = 1'b1, ex_busy = 1'b0, ex_done = 1'b0, ex_ready = 1'b1;
  logic acc_flag = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qm.delete(); ql.delete(); qd.delete();
      ex_m = 1'b1; ex_l = 1'b1; ex_busy = 1'b0; ex_done = 1'b0; ex_ready = 1'b1;
      acc_flag = 1'b0;
    end else begin
      acc_flag = din_valid && ex_ready;
      if (acc_flag) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(din[W-1-i]);
          ql.push_back(din[i]);
          qd.push_back(i == W-1);
        end
      end
      if (qm.size() != 0) begin
        ex_m = qm.pop_front(); ex_l = ql.pop_front(); ex_done = qd.pop_front();
        ex_busy = 1'b1;
      end else begin
        ex_m = 1'b1; ex_l = 1'b1; ex_done = 1'b0; ex_busy = 1'b0;
      end
      ex_ready = (qm.size() < W);
    end
  end

  always @(negedge clk) begin
    check("x_msb",     {31'd0, x_m},            {31'd0, ex_m});
    check("x_lsb",     {31'd0, x_l},            {31'd0, ex_l});
    check("busy",      {30'd0, busy_m, busy_l}, {30'd0, ex_busy, ex_busy});
    check("word_done", {30'd0, done_m, done_l}, {30'd0, ex_done, ex_done});
    check("din_ready", {30'd0, if_m.din_ready, if_l.din_ready}, {30'd0, ex_ready, ex_ready});
  end

  // Running record of what each instance actually put out while busy.
  logic [31:0] cap_m = '0, cap_l = '0;
  int busy_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (rst && busy_m) begin
      cap_m = {cap_m[30:0], x_m};
      busy_cnt++;
    end
    if (rst && busy_l) cap_l = {cap_l[30:0], x_l};
    if (rst && done_m) done_cnt++;
  end

  int last_wait = 0;

  task automatic send(input logic [W-1:0] w);
    int n;
    din       = w;
    din_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!acc_flag && n < 100);
    if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
    last_wait = n;
    din_valid = 1'b0;
  endtask

  int b0, d0;

  initial begin
    // Reset, then idle.
    repeat (3) @(posedge clk);
    #1 check("reset_x_busy_rdy", {29'd0, x_m, busy_m, if_m.din_ready}, 32'b101);
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("idle_x", {31'd0, x_m}, 32'd1);

    // Single MSB-first word.
    b0 = busy_cnt; d0 = done_cnt;
    send(8'hA5);
    check("bypass_latency", {31'd0, busy_m}, 32'd1);
    check("first_bit", {31'd0, x_m}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("a5_stream", {24'd0, cap_m[7:0]}, 32'h0000_00A5);
    check("a5_busy_len", 32'(busy_cnt - b0), 32'd8);
    check("a5_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("a5_idle_after", {30'd0, x_m, busy_m}, 32'b10);

    // Back-to-back with the second word going to the pending slot.
    b0 = busy_cnt;
    send(8'h77);
    send(8'h00);
    check("pend_ready_low", {31'd0, if_m.din_ready}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_stream", {16'd0, cap_m[15:0]}, 32'h0000_7700);
    check("b2b_busy_len", 32'(busy_cnt - b0), 32'd16);

    // Third word waits until the pending word enters the shifter.
    send(8'h0F);
    send(8'hF0);
    send(8'h3C);
    check("third_wait", 32'(last_wait), 32'd8);
    repeat (30) @(posedge clk);
    #1;
    check("three_stream", {8'd0, cap_m[23:0]}, 32'h000F_F03C);

    // LSB-first instance on a single set bit.
    send(8'h01);
    repeat (12) @(posedge clk);
    #1;
    check("lsb_stream", {24'd0, cap_l[7:0]}, 32'h0000_0080);
    check("lsb_idle_after", {31'd0, x_l}, 32'd1);

    // Reset during the 4th bit with a word pending.
    send(8'hA5);
    send(8'h55);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("midreset_outputs",
             {28'd0, x_m, busy_m, done_m, if_m.din_ready}, 32'b1001);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    b0 = busy_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("midreset_no_bits", 32'(busy_cnt - b0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
